// File: rtl/credit_sender_if.sv
//------------------------------------------------------------------------------
// credit_sender_if
//
// Bundles the two streams handled by the credit sender:
//   - push side : ready/valid stream from the upstream producer
//   - pop side  : registered valid/data stream toward the credit receiver,
//                 plus the credit return and the two reset-handshake flags
//
// Modports:
//   master : the credit sender's view (drives push_ready and the pop stream)
//   slave  : the partners' view (upstream producer and credit receiver)
//
// Signals:
//   push_ready            sender -> upstream   beat may transfer this cycle
//   push_valid            upstream -> sender   beat offered
//   push_data             upstream -> sender   payload [Width]
//   pop_sender_in_reset   sender -> receiver   sender in INIT, hold credits
//   pop_receiver_in_reset receiver -> sender   receiver in reset
//   pop_credit            receiver -> sender   one credit returned this cycle
//   pop_valid             sender -> receiver   registered beat
//   pop_data              sender -> receiver   registered payload [Width]
//------------------------------------------------------------------------------
interface credit_sender_if #(
   parameter int Width = 8
);

   logic             push_ready;
   logic             push_valid;
   logic [Width-1:0] push_data;

   logic             pop_sender_in_reset;
   logic             pop_receiver_in_reset;
   logic             pop_credit;
   logic             pop_valid;
   logic [Width-1:0] pop_data;

   modport master (
      output push_ready,
      input  push_valid,
      input  push_data,
      output pop_sender_in_reset,
      input  pop_receiver_in_reset,
      input  pop_credit,
      output pop_valid,
      output pop_data
   );

   modport slave (
      input  push_ready,
      output push_valid,
      output push_data,
      input  pop_sender_in_reset,
      output pop_receiver_in_reset,
      output pop_credit,
      input  pop_valid,
      input  pop_data
   );

endinterface : credit_sender_if

// File: rtl/credit_sender.sv
//------------------------------------------------------------------------------
// credit_sender
//
// Upstream half of a credit-based link. Accepts a ready/valid push stream,
// spends one credit per transferred beat and forwards the beat on a
// registered pop stream. Credits returned by the receiver refill the counter.
// A two-state handshake (INIT / ACTIVE) reloads the credit counter whenever
// either side is in reset so both ends agree on the credit state.
//
// Parameters:
//   Width      payload width
//   MaxCredit  largest credit count the counter can hold (must be >= 1)
//   CountWidth derived counter width, not overridable
//
// Ports:
//   clk               clock, all state on the rising edge
//   rst_n             asynchronous active-low reset
//   bus               credit_sender_if.master (push and pop streams)
//   credit_initial    credits loaded while in INIT, clamped to MaxCredit
//   credit_withhold   credits held back from use, may change any cycle
//   credit_count      registered credit counter
//   credit_available  spendable credits (combinational)
//------------------------------------------------------------------------------
module credit_sender #(
   parameter  int Width      = 8,
   parameter  int MaxCredit  = 4,
   localparam int CountWidth = $clog2(MaxCredit + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   credit_sender_if.master       bus,
   input  logic [CountWidth-1:0] credit_initial,
   input  logic [CountWidth-1:0] credit_withhold,
   output logic [CountWidth-1:0] credit_count,
   output logic [CountWidth-1:0] credit_available
);

   localparam logic [CountWidth-1:0] MaxCount     = CountWidth'(MaxCredit);
   localparam logic [CountWidth:0]   MaxCountWide = (CountWidth + 1)'(MaxCredit);

   typedef enum logic {
      ST_INIT   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   state_e                r_state;
   state_e                w_state_next;

   logic [CountWidth-1:0] r_count;
   logic [CountWidth-1:0] w_count_next;
   logic [CountWidth-1:0] w_init_clamped;
   logic [CountWidth-1:0] w_available;
   logic [CountWidth:0]   w_count_sum;
   logic [CountWidth-1:0] w_count_sat;

   logic                  w_push_ready;
   logic                  w_beat;
   logic                  r_pop_valid;
   logic                  w_pop_valid_next;
   logic [Width-1:0]      r_pop_data;

   //---------------------------------------------------------------------------
   // Credit arithmetic
   //---------------------------------------------------------------------------

   // Reload value used whenever the link (re)enters or sits in INIT.
   assign w_init_clamped = (credit_initial > MaxCount) ? MaxCount : credit_initial;

   // Withheld credits are never spendable; the difference cannot go negative.
   assign w_available = (r_count > credit_withhold) ? (r_count - credit_withhold)
                                                    : '0;

   // Ready is blocked in the same cycle the receiver signals reset, so a beat
   // offered on the INIT transition edge is never accepted and then lost.
   assign w_push_ready = (r_state == ST_ACTIVE)
                       & ~bus.pop_receiver_in_reset
                       & (w_available != '0);

   assign w_beat = bus.push_valid & w_push_ready;

   // One extra bit so an illegal extra credit at MaxCredit is caught by the
   // saturation compare instead of wrapping to zero. A beat implies
   // r_count >= 1, so the subtraction never underflows.
   assign w_count_sum = {1'b0, r_count}
                      + (CountWidth + 1)'(bus.pop_credit)
                      - (CountWidth + 1)'(w_beat);

   assign w_count_sat = (w_count_sum > MaxCountWide) ? MaxCount
                                                     : w_count_sum[CountWidth-1:0];

   //---------------------------------------------------------------------------
   // Handshake FSM: next state, next counter and next pop_valid
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      w_state_next     = r_state;
      w_count_next     = r_count;
      w_pop_valid_next = 1'b0;

      unique case (r_state)
         ST_INIT: begin
            // Credit returns are ignored here; the counter simply tracks the
            // configured initial value until the receiver leaves reset.
            w_count_next = w_init_clamped;
            if (!bus.pop_receiver_in_reset) begin
               w_state_next = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (bus.pop_receiver_in_reset) begin
               // Receiver reset: drop any credit/beat from this cycle and
               // reload, so both sides restart from the same credit count.
               w_state_next = ST_INIT;
               w_count_next = w_init_clamped;
            end else begin
               w_count_next     = w_count_sat;
               w_pop_valid_next = w_beat;
            end
         end

         default: begin
            w_state_next = ST_INIT;
            w_count_next = w_init_clamped;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_count     <= '0;
         r_pop_valid <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the values from before this edge.
         r_state     <= w_state_next;
         r_count     <= w_count_next;
         r_pop_valid <= w_pop_valid_next;
      end
   end

   // Payload register only loads on a transferred beat and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload register is reset as well so pop_data is a known
         // zero out of reset, not left as an unreset datapath register.
         r_pop_data <= '0;
      end else if (w_beat) begin
         r_pop_data <= bus.push_data;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign bus.push_ready          = w_push_ready;
   assign bus.pop_sender_in_reset = (r_state == ST_INIT);
   assign bus.pop_valid           = r_pop_valid;
   assign bus.pop_data            = r_pop_data;

   assign credit_count     = r_count;
   assign credit_available = w_available;

endmodule : credit_sender

// File: doc/credit_sender.md
# credit_sender

Upstream partner of the credit receiver. Accepts a ready/valid push stream, spends one credit per transferred beat, and drives a registered valid/data pop stream toward the receiver. Credits returned by the receiver on `pop_credit` replenish the counter. A two-state reset handshake keeps both sides' credit state consistent when either side resets.

## Interface
Parameters:
- `Width`, 8, data width of push/pop payload.
- `MaxCredit`, 4, maximum credit count; must be ≥1.
- `CountWidth`, `$clog2(MaxCredit+1)`, derived localparam, not overridable.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `push_ready`  out  1  upstream may transfer this cycle.
- `push_valid`  in  1  upstream beat offered.
- `push_data`  in  Width  upstream payload.
- `pop_sender_in_reset`  out  1  this block is in INIT; receiver must not return credits.
- `pop_receiver_in_reset`  in  1  receiver is in reset.
- `pop_credit`  in  1  one credit returned this cycle.
- `pop_valid`  out  1  registered beat to receiver.
- `pop_data`  out  Width  registered payload.
- `credit_initial`  in  CountWidth  credits loaded in INIT; values above MaxCredit clamp to MaxCredit.
- `credit_withhold`  in  CountWidth  credits held back from use; may change any cycle.
- `credit_count`  out  CountWidth  current counter value (registered).
- `credit_available`  out  CountWidth  spendable credits (combinational).

## Operation
- FSM states: INIT, ACTIVE.
- INIT:
  - `pop_sender_in_reset`=1, `push_ready`=0.
  - `pop_credit` is ignored.
  - `credit_count` <= min(credit_initial, MaxCredit) every cycle.
  - Transition to ACTIVE on the first edge where `pop_receiver_in_reset`=0.
- ACTIVE:
  - `pop_sender_in_reset`=0.
  - If `pop_receiver_in_reset`=1, go to INIT on that edge. `credit_count` <= clamped `credit_initial`. `pop_valid` <= 0. Any `pop_credit` or push beat in that cycle is discarded; `push_ready` is forced 0 in that cycle.
- Spendable credits: `credit_available` = (count > withhold) ? count − withhold : 0.
- `push_ready` = ACTIVE & ~`pop_receiver_in_reset` & (`credit_available` ≠ 0). It never depends on `push_valid`.
- A beat is transferred when `push_valid` & `push_ready`.
- Counter update in ACTIVE: count_next = count + `pop_credit` − beat, computed at CountWidth+1 bits.
  - If the result exceeds MaxCredit, the counter saturates at MaxCredit. This is a protocol error, but the counter must not wrap.
  - Underflow cannot occur, because a beat requires count ≥ 1.
- Pop register: `pop_valid` <= beat. `pop_data` <= `push_data` on a beat; otherwise it holds its value.

## Timing
- Reset values (`rst_n`=0, async): state=INIT, `credit_count`=0, `pop_valid`=0, `pop_data`=0, `pop_sender_in_reset`=1, `push_ready`=0.
- First ACTIVE cycle: the edge after `rst_n` deasserts, provided `pop_receiver_in_reset`=0 is sampled at that edge.
- Push-to-pop latency: 1 cycle. A beat accepted at edge N appears on `pop_valid`/`pop_data` during cycle N+1.
- Credit-return latency: 1 cycle. `pop_credit` at edge N raises `credit_count` and `push_ready` after edge N. A beat and a credit return in the same cycle leave the count unchanged.
- `credit_withhold` changes take effect combinationally in the same cycle on `credit_available` and `push_ready`.
- `pop_valid` may be high on consecutive cycles (full throughput while credits remain).

## Test plan
- Reset handshake: `rst_n`=0 for 3 cycles, `credit_initial`=3, `pop_receiver_in_reset`=1 for 2 cycles after release.
  - `pop_sender_in_reset`=1 and `push_ready`=0 throughout.
  - Then ACTIVE with `credit_count`=3 and `push_ready`=1.
- Drain: MaxCredit=4, initial=2, `push_valid` held with data 0xA1, 0xA2, 0xA3.
  - Exactly 0xA1 and 0xA2 transfer; `pop_valid` is high on the two following cycles.
  - `credit_count`=0, `push_ready`=0, and 0xA3 is still pending.
  - One `pop_credit` pulse then transfers 0xA3 on the next cycle.
- Simultaneous beat and credit: count=1, beat plus `pop_credit` in the same cycle.
  - Count stays 1; `push_ready` stays 1 for back-to-back beats.
- Withhold:
  - count=3, `credit_withhold`=2 → `credit_available`=1, `push_ready`=1.
  - `credit_withhold`=3 → `credit_available`=0 and `push_ready`=0 in the same cycle.
- Saturation: count=4 (MaxCredit), `pop_credit`=1, no push → count stays 4, no wrap to 0.
- Receiver reset mid-stream: ACTIVE, count=1, `pop_receiver_in_reset`=1 with `push_valid`=1 and `pop_credit`=1.
  - No beat transfers; next cycle state=INIT, `pop_valid`=0, count=`credit_initial`.
  - Returns to ACTIVE one edge after `pop_receiver_in_reset` drops.
